pipe_ctrl: RTL and testbench

Pipeline control unit for the 5-stage MIPS core. Merges stall requests from ID, EX and MEM with exceptions from MEM, debug halt and a stall watchdog. Drives the shared `stall[5:0]`, `flush` and `new_pc` buses consumed by the PC register and every pipeline latch. Sequential state tracks flush recovery, debug halt and stall duration.

---
 rtl/pipe_ctrl_pkg.sv | 29 ++
 rtl/pipe_ctrl_perf.sv | 34 +++
 rtl/pipe_ctrl.sv | 125 ++++++++++++
 tb/tb_pipe_ctrl.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline control unit: FSM states, stall masks,
// the eret exception code and the default exception entry address.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [5:0]  STALL_NONE = 6'b000000;
  localparam logic [5:0]  STALL_ID   = 6'b000111;
  localparam logic [5:0]  STALL_EX   = 6'b001111;
  localparam logic [5:0]  STALL_MEM  = 6'b011111;
  localparam logic [5:0]  STALL_ALL  = 6'b111111;

  localparam logic [31:0] EXC_ERET           = 32'h0000_000e;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0040;

  // The deepest requesting stage wins, since it also freezes every stage above it.
  function automatic logic [5:0] stall_mask(input logic id, input logic ex, input logic mem);
    if (mem)     return STALL_MEM;
    else if (ex) return STALL_EX;
    else if (id) return STALL_ID;
    else         return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_perf.sv
// Saturating performance counters: cycles spent stalled and number of flush pulses.
module pipe_ctrl_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_any_i,
  input  logic        flush_i,
  output logic [31:0] perf_stall_cycles_o,
  output logic [15:0] perf_flush_count_o
);

  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_count_d  = flush_count_q;
    if (stall_any_i && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 32'd1;
    if (flush_i && (flush_count_q != '1))      flush_count_d  = flush_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_count_q  <= flush_count_d;
    end
  end

  assign perf_stall_cycles_o = stall_cycles_q;
  assign perf_flush_count_o  = flush_count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control unit: merges stage stall requests, MEM exceptions, debug halt
// and a stall watchdog into stall/flush/new_pc. Optional counters: PIPE_CTRL_PERF_EN.
//
// state | meaning
// RUN   | pipeline flowing; requests evaluated by priority
// STALL | at least one stage held last cycle; watchdog counting
// FLUSH | one-cycle bubble after a redirect; all requests ignored
// HALT  | debug freeze; everything held until resume
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR    = EXC_VECTOR_DEFAULT,
  parameter int          STALL_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id_i,
  input  logic        stallreq_ex_i,
  input  logic        stallreq_mem_i,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        halt_req_i,
  input  logic        resume_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        halted_o,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] perf_stall_cycles_o,
  output logic [15:0] perf_flush_count_o,
`endif
  output logic        timeout_o
);

  localparam logic [15:0] WD_LAST = 16'(STALL_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;

  logic active, any_req, exc_hit, wd_hit, halt_hit;

  assign active   = (state_q == ST_RUN) || (state_q == ST_STALL);
  assign any_req  = stallreq_id_i | stallreq_ex_i | stallreq_mem_i;
  assign exc_hit  = active && (excepttype_i != 32'd0);
  assign wd_hit   = (state_q == ST_STALL) && any_req && (stall_cnt_q == WD_LAST);
  assign halt_hit = active && halt_req_i;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (exc_hit || wd_hit) state_d = ST_FLUSH;
        else if (halt_hit)     state_d = ST_HALT;
        else if (any_req)      state_d = ST_STALL;
        else                   state_d = ST_RUN;
      end
      ST_FLUSH: state_d = ST_RUN;
      ST_HALT:  state_d = resume_i ? ST_RUN : ST_HALT;
      default:  state_d = ST_RUN;
    endcase
  end

  // Count only consecutive STALL cycles, so the first STALL cycle sees 0.
  always_comb begin
    stall_cnt_d = '0;
    if ((state_q == ST_STALL) && (state_d == ST_STALL)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_comb begin
    stall     = STALL_NONE;
    flush     = 1'b0;
    new_pc    = 32'd0;
    halted_o  = 1'b0;
    timeout_o = 1'b0;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (exc_hit) begin
          flush  = 1'b1;
          new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
        end else if (wd_hit) begin
          flush     = 1'b1;
          new_pc    = EXC_VECTOR;
          timeout_o = 1'b1;
        end else if (!halt_hit) begin
          stall = stall_mask(stallreq_id_i, stallreq_ex_i, stallreq_mem_i);
        end
      end
      ST_HALT: begin
        stall    = STALL_ALL;
        halted_o = 1'b1;
      end
      default: ;
    endcase
    // Hold everything quiet while reset is asserted.
    if (!rst) begin
      stall     = STALL_NONE;
      flush     = 1'b0;
      new_pc    = 32'd0;
      halted_o  = 1'b0;
      timeout_o = 1'b0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  pipe_ctrl_perf u_perf (
    .clk                 (clk),
    .rst                 (rst),
    .stall_any_i         (stall != STALL_NONE),
    .flush_i             (flush),
    .perf_stall_cycles_o (perf_stall_cycles_o),
    .perf_flush_count_o  (perf_flush_count_o)
  );
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a per-cycle vector table plus hand sequences for
// PC advance around a stall and after an exception redirect.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_id_i, stallreq_ex_i, stallreq_mem_i;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic        halt_req_i, resume_i;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        halted_o, timeout_o;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles_o;
  logic [15:0] perf_flush_count_o;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.EXC_VECTOR(32'h0000_0040), .STALL_TIMEOUT(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .stallreq_id_i  (stallreq_id_i),
    .stallreq_ex_i  (stallreq_ex_i),
    .stallreq_mem_i (stallreq_mem_i),
    .excepttype_i   (excepttype_i),
    .cp0_epc_i      (cp0_epc_i),
    .halt_req_i     (halt_req_i),
    .resume_i       (resume_i),
    .stall          (stall),
    .flush          (flush),
    .new_pc         (new_pc),
    .halted_o       (halted_o),
`ifdef PIPE_CTRL_PERF_EN
    .perf_stall_cycles_o (perf_stall_cycles_o),
    .perf_flush_count_o  (perf_flush_count_o),
`endif
    .timeout_o      (timeout_o)
  );

  // Consumer-side PC register, as the core's fetch stage would behave.
  logic [31:0] pc_q;
  always @(posedge clk) begin
    if (!rst)            pc_q <= 32'd0;
    else if (flush)      pc_q <= new_pc;
    else if (!stall[0])  pc_q <= pc_q + 32'd4;
  end

  typedef struct {
    logic        r, id, ex, mem;
    logic [31:0] exc, epc;
    logic        halt, res;
    logic [5:0]  e_stall;
    logic        e_flush;
    logic [31:0] e_pc;
    logic        e_halted, e_to;
  } vec_t;

  vec_t vecs[$];
  int   passed = 0;
  int   total  = 0;

  task automatic add(input logic r, id, ex, mem, input logic [31:0] exc, epc,
                     input logic halt, res, input logic [5:0] es, input logic ef,
                     input logic [31:0] ep, input logic eh, et);
    vec_t v;
    v.r = r; v.id = id; v.ex = ex; v.mem = mem; v.exc = exc; v.epc = epc;
    v.halt = halt; v.res = res; v.e_stall = es; v.e_flush = ef; v.e_pc = ep;
    v.e_halted = eh; v.e_to = et;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic r, id, ex, mem, input logic [31:0] exc, epc,
                       input logic halt, res);
    rst = r; stallreq_id_i = id; stallreq_ex_i = ex; stallreq_mem_i = mem;
    excepttype_i = exc; cp0_epc_i = epc; halt_req_i = halt; resume_i = res;
  endtask

  logic        prev_flush = 1'b0;
  logic [31:0] pc0;

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    //   r id ex mem exc      epc        h  rs  stall      fl pc         hl to
    add(0, 0, 0, 0, 32'h0,  32'h0,    0, 0, 6'b000000, 0, 32'h0,    0, 0); // reset
    add(0, 0, 0, 1, 32'h8,  32'h0,    1, 0, 6'b000000, 0, 32'h0,    0, 0); // reset masks inputs
    add(1, 0, 0, 0, 32'h0,  32'h0,    0, 0, 6'b000000, 0, 32'h0,    0, 0);
    add(1, 0, 1, 0, 32'h0,  32'h0,    0, 0, 6'b001111, 0, 32'h0,    0, 0); // EX stall x3
    add(1, 0, 1, 0, 32'h0,  32'h0,    0, 0, 6'b001111, 0, 32'h0,    0, 0);
    add(1, 0, 1, 0, 32'h0,  32'h0,    0, 0, 6'b001111, 0, 32'h0,    0, 0);
    add(1, 0, 0, 0, 32'h0,  32'h0,    0, 0, 6'b000000, 0, 32'h0,    0, 0);
    add(1, 1, 0, 1, 32'h0,  32'h0,    0, 0, 6'b011111, 0, 32'h0,    0, 0); // ID+MEM
    add(1, 1, 0, 0, 32'h0,  32'h0,    0, 0, 6'b000111, 0, 32'h0,    0, 0); // ID only
    add(1, 0, 0, 0, 32'h0,  32'h0,    0, 0, 6'b000000, 0, 32'h0,    0, 0);
    add(1, 0, 0, 1, 32'h8,  32'h0,    0, 0, 6'b000000, 1, 32'h40,   0, 0); // exception
    add(1, 0, 0, 1, 32'h8,  32'h0,    0, 0, 6'b000000, 0, 32'h0,    0, 0); // FLUSH ignores
    add(1, 0, 0, 0, 32'h0,  32'h0,    0, 0, 6'b000000, 0, 32'h0,    0, 0);
    add(1, 0, 0, 0, 32'he,  32'h1234, 0, 0, 6'b000000, 1, 32'h1234, 0, 0); // eret
    add(1, 0, 0, 0, 32'he,  32'h1234, 0, 0, 6'b000000, 0, 32'h0,    0, 0);
    add(1, 0, 0, 0, 32'h0,  32'h0,    0, 0, 6'b000000, 0, 32'h0,    0, 0);
    for (int i = 0; i < 8; i++)                                              // RUN + 7 STALL
      add(1, 0, 0, 1, 32'h0, 32'h0,   0, 0, 6'b011111, 0, 32'h0,    0, 0);
    add(1, 0, 0, 1, 32'h0,  32'h0,    0, 0, 6'b000000, 1, 32'h40,   0, 1); // 8th STALL: watchdog
    add(1, 0, 0, 1, 32'h0,  32'h0,    0, 0, 6'b000000, 0, 32'h0,    0, 0);
    add(1, 0, 0, 0, 32'h0,  32'h0,    0, 0, 6'b000000, 0, 32'h0,    0, 0);
    add(1, 0, 0, 0, 32'h0,  32'h0,    1, 0, 6'b000000, 0, 32'h0,    0, 0); // halt accepted
    add(1, 0, 0, 0, 32'h0,  32'h0,    1, 0, 6'b111111, 0, 32'h0,    1, 0);
    add(1, 0, 0, 1, 32'h8,  32'h0,    1, 0, 6'b111111, 0, 32'h0,    1, 0); // ignored in HALT
    add(1, 0, 0, 0, 32'h0,  32'h0,    1, 1, 6'b111111, 0, 32'h0,    1, 0); // resume
    add(1, 0, 0, 0, 32'h0,  32'h0,    1, 0, 6'b000000, 0, 32'h0,    0, 0); // single-step RUN
    add(1, 0, 0, 0, 32'h0,  32'h0,    1, 0, 6'b111111, 0, 32'h0,    1, 0); // re-halted
    add(0, 0, 0, 0, 32'h0,  32'h0,    1, 0, 6'b000000, 0, 32'h0,    0, 0); // reset mid-HALT
    add(1, 0, 0, 0, 32'h0,  32'h0,    0, 0, 6'b000000, 0, 32'h0,    0, 0);
    add(1, 0, 0, 0, 32'h0,  32'h0,    0, 1, 6'b000000, 0, 32'h0,    0, 0); // stray resume
    add(1, 0, 0, 1, 32'h0,  32'h0,    0, 0, 6'b011111, 0, 32'h0,    0, 0);
    add(1, 0, 0, 1, 32'h0,  32'h0,    1, 0, 6'b000000, 0, 32'h0,    0, 0); // halt preempts STALL
    add(1, 0, 0, 1, 32'h0,  32'h0,    0, 0, 6'b111111, 0, 32'h0,    1, 0);
    add(1, 0, 0, 1, 32'h0,  32'h0,    0, 1, 6'b111111, 0, 32'h0,    1, 0);
    add(1, 0, 0, 1, 32'h0,  32'h0,    0, 0, 6'b011111, 0, 32'h0,    0, 0); // re-evaluated in RUN
    add(1, 0, 0, 0, 32'h0,  32'h0,    0, 0, 6'b000000, 0, 32'h0,    0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].r, vecs[i].id, vecs[i].ex, vecs[i].mem, vecs[i].exc, vecs[i].epc,
            vecs[i].halt, vecs[i].res);
      #1;
      chk($sformatf("v%0d stall", i),   32'(stall),     32'(vecs[i].e_stall));
      chk($sformatf("v%0d flush", i),   32'(flush),     32'(vecs[i].e_flush));
      chk($sformatf("v%0d new_pc", i),  new_pc,         vecs[i].e_pc);
      chk($sformatf("v%0d halted", i),  32'(halted_o),  32'(vecs[i].e_halted));
      chk($sformatf("v%0d timeout", i), 32'(timeout_o), 32'(vecs[i].e_to));
      chk($sformatf("v%0d flush_twice", i), 32'(flush && prev_flush), 32'd0);
      prev_flush = flush;
    end

    // PC must hold through a 3-cycle EX stall and advance only after release.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1 pc0 = pc_q;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1, 0, 1, 0, 0, 0, 0, 0);
      #1;
      chk($sformatf("pc_hold%0d", k), pc_q, (k == 0) ? pc0 + 32'd4 : pc0 + 32'd4);
    end
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("pc_release_stall", 32'(stall), 32'd0);
    chk("pc_still_held", pc_q, pc0 + 32'd4);
    @(negedge clk);
    #1 chk("pc_advance", pc_q, pc0 + 32'd8);

    // Redirect lands in the PC one edge after the exception is seen.
    @(negedge clk);
    drive(1, 0, 0, 0, 32'h8, 0, 0, 0);
    #1 chk("exc_flush", 32'(flush), 32'd1);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("pc_redirect", pc_q, 32'h40);
    chk("exc_flush_single", 32'(flush), 32'd0);
    @(negedge clk);
    #1 chk("pc_after_redirect", pc_q, 32'h44);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

endmodule
